// File: rtl/copy_multicast.sv
// Buffered eager-fork multicast: one input channel, NOUT outputs, DEPTH-entry FIFO.
// Each selected output handshakes independently; the head retires once all its outputs have fired.
module copy_multicast #(
  parameter int WIDTH     = 4,
  parameter int NOUT      = 2,
  parameter int DEPTH     = 4,
  parameter int CNT_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      L_data,
  input  logic [NOUT-1:0]       L_mask,
  input  logic                  L_valid,
  output logic                  L_ready,
  output logic [NOUT*WIDTH-1:0] R_data,
  output logic [NOUT-1:0]       R_valid,
  input  logic [NOUT-1:0]       R_ready,
  output logic [CNT_WIDTH-1:0]  pkt_count,
  output logic [CNT_WIDTH-1:0]  drop_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  logic [WIDTH-1:0] data_mem [DEPTH];
  logic [NOUT-1:0]  mask_mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [OCC_W-1:0] occ;
  logic [NOUT-1:0]  sent;

  logic [WIDTH-1:0] head_data;
  logic [NOUT-1:0]  head_mask;
  logic [NOUT-1:0]  fire;
  logic             full, empty, push, retire;

  assign head_data = data_mem[rd_ptr];
  assign head_mask = mask_mem[rd_ptr];
  assign full      = (occ == FULL_OCC);
  assign empty     = (occ == '0);

  // No bypass: a pop in the same cycle does not reopen a full FIFO.
  assign L_ready = !rst && !full;
  assign push    = L_valid && L_ready;

  assign R_data  = {NOUT{head_data}};
  assign R_valid = (rst || empty) ? '0 : (head_mask & ~sent);
  assign fire    = R_valid & R_ready;
  // Zero-mask heads satisfy this immediately and retire as drops.
  assign retire  = !rst && !empty && ((head_mask & ~(sent | fire)) == '0);

  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr] <= L_data;
      mask_mem[wr_ptr] <= L_mask;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      occ        <= '0;
      sent       <= '0;
      pkt_count  <= '0;
      drop_count <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (retire)
        rd_ptr <= rd_ptr + PTR_W'(1);

      case ({push, retire})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase

      if (retire) begin
        sent <= '0;
        if (|head_mask)
          pkt_count <= pkt_count + CNT_WIDTH'(1);
        else
          drop_count <= sat_inc(drop_count);
      end else begin
        sent <= sent | fire;
      end
    end
  end

endmodule

// File: tb/tb_copy_multicast.sv
// Directed bench for copy_multicast (WIDTH=4, NOUT=2, DEPTH=4, CNT_WIDTH=8).
module tb_copy_multicast;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] L_data;
  logic [1:0] L_mask;
  logic       L_valid;
  logic       L_ready;
  logic [7:0] R_data;
  logic [1:0] R_valid;
  logic [1:0] R_ready;
  logic [7:0] pkt_count;
  logic [7:0] drop_count;

  int n_checks = 0;
  int n_pass   = 0;

  copy_multicast #(.WIDTH(4), .NOUT(2), .DEPTH(4), .CNT_WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .L_data    (L_data),
    .L_mask    (L_mask),
    .L_valid   (L_valid),
    .L_ready   (L_ready),
    .R_data    (R_data),
    .R_valid   (R_valid),
    .R_ready   (R_ready),
    .pkt_count (pkt_count),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Advance one edge; inputs change 1ns after the edge, checks 1ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] exp_q [4];

  initial begin
    rst = 1'b1; L_valid = 1'b1; L_data = 4'h0; L_mask = 2'b11; R_ready = 2'b00;

    // Reset held three cycles with L_valid high
    for (int i = 0; i < 3; i++) begin
      step(); #1;
      chk("rst_lready", L_ready, 0);
      chk("rst_rvalid", R_valid, 0);
      chk("rst_pkt", pkt_count, 0);
      chk("rst_drop", drop_count, 0);
    end
    rst = 1'b0; L_valid = 1'b0; #1;
    chk("post_rst_lready", L_ready, 1);
    chk("post_rst_rvalid", R_valid, 0);

    // Broadcast 0xA to both outputs, both ready
    L_data = 4'hA; L_mask = 2'b11; L_valid = 1'b1; R_ready = 2'b11;
    step(); L_valid = 1'b0; #1;
    chk("bc_rvalid", R_valid, 2'b11);
    chk("bc_rdata", R_data, 8'hAA);
    chk("bc_pkt_before", pkt_count, 0);
    step(); #1;
    chk("bc_pkt", pkt_count, 1);
    chk("bc_rvalid_after", R_valid, 0);

    // R1 stalled for four cycles while R0 fires once
    L_data = 4'h5; L_mask = 2'b11; L_valid = 1'b1; R_ready = 2'b01;
    step(); L_valid = 1'b0; #1;
    chk("stall_rvalid0", R_valid, 2'b11);
    chk("stall_rdata0", R_data, 8'h55);
    for (int i = 0; i < 3; i++) begin
      step(); #1;
      chk("stall_rvalid", R_valid, 2'b10);
      chk("stall_rdata1", R_data[7:4], 4'h5);
      chk("stall_pkt", pkt_count, 1);
    end
    R_ready = 2'b11; #1;
    chk("stall_release_rvalid", R_valid, 2'b10);
    step(); #1;
    chk("stall_pkt_retired", pkt_count, 2);
    chk("stall_rvalid_done", R_valid, 0);

    // Fill the FIFO with outputs blocked
    R_ready = 2'b00; L_mask = 2'b01; L_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      L_data = 4'(i + 1); #1;
      chk("fill_lready", L_ready, 1);
      step();
    end
    L_data = 4'h6; #1;
    chk("full_lready", L_ready, 0);
    step(); #1;
    chk("full_hold_lready", L_ready, 0);
    chk("full_rvalid", R_valid, 2'b01);
    chk("full_head", R_data[3:0], 4'h1);
    R_ready = 2'b01; #1;
    chk("full_nobypass", L_ready, 0);
    step(); R_ready = 2'b00; #1;
    chk("after_pop_lready", L_ready, 1);
    chk("after_pop_head", R_data[3:0], 4'h2);
    step(); L_valid = 1'b0; #1;
    chk("fifth_full", L_ready, 0);
    exp_q[0] = 4'h2; exp_q[1] = 4'h3; exp_q[2] = 4'h4; exp_q[3] = 4'h6;
    R_ready = 2'b01;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("drain_rvalid", R_valid, 2'b01);
      chk("drain_data", R_data[3:0], exp_q[i]);
      step();
    end
    #1;
    chk("drain_empty", R_valid, 0);
    chk("drain_pkt", pkt_count, 7);

    // Zero-mask packet followed by mask 10
    R_ready = 2'b11; L_data = 4'h3; L_mask = 2'b00; L_valid = 1'b1;
    step(); L_data = 4'h7; L_mask = 2'b10; #1;
    chk("zero_rvalid", R_valid, 0);
    step(); L_valid = 1'b0; #1;
    chk("zero_drop", drop_count, 1);
    chk("m10_rvalid", R_valid, 2'b10);
    chk("m10_data", R_data[7:4], 4'h7);
    step(); #1;
    chk("m10_pkt", pkt_count, 8);
    chk("m10_rvalid_after", R_valid, 0);

    // drop_count saturation
    L_mask = 2'b00; L_data = 4'h0; L_valid = 1'b1;
    for (int i = 0; i < 300; i++) step();
    L_valid = 1'b0;
    step(); #1;
    chk("drop_sat", drop_count, 8'd255);
    chk("drop_sat_pkt", pkt_count, 8);
    chk("drop_sat_empty", R_valid, 0);

    // Reset while a broadcast is half delivered
    L_data = 4'h9; L_mask = 2'b11; L_valid = 1'b1; R_ready = 2'b01;
    step(); L_valid = 1'b0; #1;
    chk("mid_rvalid0", R_valid, 2'b11);
    step(); #1;
    chk("mid_rvalid1", R_valid, 2'b10);
    rst = 1'b1; #1;
    chk("mid_rst_rvalid", R_valid, 0);
    chk("mid_rst_lready", L_ready, 0);
    step(); rst = 1'b0; R_ready = 2'b11; #1;
    chk("mid_after_lready", L_ready, 1);
    chk("mid_after_pkt", pkt_count, 0);
    chk("mid_after_drop", drop_count, 0);
    for (int i = 0; i < 3; i++) begin
      chk("mid_never_r1", R_valid, 0);
      step(); #1;
    end
    chk("mid_pkt_final", pkt_count, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/copy_multicast.md
Name: copy_multicast

Overview:
Clocked, buffered, parametrised successor to the two-way copy/fork element. It accepts a packet plus a per-packet destination mask on one input channel and delivers the packet to every selected output among NOUT output channels. Each output completes its handshake independently (eager fork), so a slow output does not stall delivery to the others. An internal FIFO of DEPTH entries decouples the input from the outputs. It sits in the PE/NoC datapath wherever one producer feeds several consumers.

Parameters:
WIDTH, 4, packet data width in bits
NOUT, 2, number of output channels (>=2)
DEPTH, 4, FIFO entries; power of two, >=2
CNT_WIDTH, 8, width of the statistics counters

Ports:
clk  input  1  clock; all state changes on rising edge
rst  input  1  synchronous, active-high reset
L_data  input  WIDTH  input packet
L_mask  input  NOUT  destination mask; bit i selects output i
L_valid  input  1  input packet present
L_ready  output  1  block can accept a packet
R_data  output  NOUT*WIDTH  output data; slice i is [i*WIDTH +: WIDTH]
R_valid  output  NOUT  per-output valid
R_ready  input  NOUT  per-output ready
pkt_count  output  CNT_WIDTH  packets retired with a nonzero mask; wraps
drop_count  output  CNT_WIDTH  packets retired with a zero mask; saturates

Behaviour:
- Reset (rst high at an edge): rd/wr pointers, occupancy, sent bits, pkt_count and drop_count are cleared to 0. While rst is high, L_ready=0 and R_valid=0. Reset mid-operation discards all entries, including partially delivered ones. From the first cycle after reset: L_ready=1, R_valid=0.
- Push: occurs when L_valid && L_ready at an edge; {L_data, L_mask} is written at wr_ptr.
- L_ready is !full, i.e. occupancy<DEPTH. There is no same-cycle bypass of a full FIFO: when full, L_ready=0 even if a pop occurs in the same cycle.
- Latency: a packet pushed at edge k into an empty FIFO drives R_valid from the cycle after edge k. The input-to-output path is not combinational.
- Head outputs: all R_data slices equal the head data. R_valid[i] = !empty && head_mask[i] && !sent[i].
- Output fire[i] = R_valid[i] && R_ready[i]. At the edge, sent[i] is set for every fired output.
- Once R_valid[i] is asserted, it stays high and R_data stays stable until output i fires. R_ready has no combinational effect on L_ready.
- Retire condition: (head_mask & ~(sent | fire)) == 0, evaluated in the cycle. On retire at the edge:
  - pop the head;
  - clear all sent bits;
  - increment pkt_count (nonzero mask) or drop_count (zero mask).
- Zero mask: the head retires in its first head cycle, asserts no R_valid, and increments drop_count. drop_count saturates at 2^CNT_WIDTH-1.
- Throughput: when all selected outputs are ready, one packet retires per cycle. Simultaneous push and pop is allowed when not full; occupancy is unchanged.
- Outputs fired in the same cycle as the retire are not re-presented: the next head's R_valid reflects only its own mask.
- Pointers wrap modulo DEPTH. pkt_count wraps modulo 2^CNT_WIDTH.
- Occupancy counter width: $clog2(DEPTH)+1.

Test Plan:
1. Reset held 3 cycles with L_valid=1 -> L_ready=0, R_valid=0, both counters 0. L_ready=1 in the first cycle after rst falls.
2. NOUT=2, push 0xA with mask 2'b11, both R_ready=1 -> R_valid=2'b11 with data 0xA one cycle after the push. Retires in that cycle; pkt_count=1.
3. Push 0x5 with mask 11. Hold R_ready[1]=0 for 4 cycles.
   - R0 fires once; R_valid[0] stays 0 thereafter.
   - R_valid[1] stays high with data 0x5 throughout.
   - The packet retires only on the cycle R_ready[1] rises.
4. DEPTH=4, all R_ready=0, push 5 packets with mask 01 -> the 4th push fills the FIFO and L_ready drops to 0. The 5th is accepted the cycle after one pop. Data emerges on R0 in order.
5. Push 0x3 with mask 00, then 0x7 with mask 10 -> drop_count=1, R_valid[0] never asserts, R1 receives 0x7. Separately, 300 zero-mask packets give drop_count=255.
6. Assert rst while a mask-11 packet has fired only R0 -> after reset, R_valid=0, the FIFO is empty, and the packet is never delivered to R1.
